riscv_id_ex_ctrl_stage: RTL and testbench

//  Registered decode-to-execute control stage for the RV32 pipeline.
//  - Decodes instrD into the main/ALU control bundle, then registers it into the E stage.
//  - Adds the optional M extension: MUL/DIV ops occupy E for a programmable latency and raise a stall.
//  - Also adds illegal-instruction flagging and stall/flush with bubble insertion.

---
 rtl/riscv_ctrl_pkg.sv | 79 +++++++
 rtl/riscv_ctrl_decode.sv | 108 ++++++++++
 rtl/riscv_id_ex_ctrl_stage.sv | 87 ++++++++
 tb/tb_riscv_id_ex_ctrl_stage.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32 decode/execute control path:
// opcodes, ALU codes, mux selects and the bundle that travels from D to E.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_SLT  = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_SRA  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   localparam logic [1:0] RESULT_ALU = 2'd0;
   localparam logic [1:0] RESULT_MEM = 2'd1;
   localparam logic [1:0] RESULT_PC4 = 2'd2;

   localparam logic [1:0] JUMP_NONE = 2'd0;
   localparam logic [1:0] JUMP_JAL  = 2'd1;
   localparam logic [1:0] JUMP_JALR = 2'd2;

   localparam logic [2:0] BRANCH_NONE = 3'd0;
   localparam logic [2:0] BRANCH_BEQ  = 3'd1;
   localparam logic [2:0] BRANCH_BNE  = 3'd2;
   localparam logic [2:0] BRANCH_BLT  = 3'd3;
   localparam logic [2:0] BRANCH_BGE  = 3'd4;
   localparam logic [2:0] BRANCH_BLTU = 3'd5;
   localparam logic [2:0] BRANCH_BGEU = 3'd6;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       alu_src;
      logic       lui;
      logic [1:0] result_src;
      logic [1:0] jump;
      logic [2:0] branch;
      logic [2:0] imm_src;
      logic [3:0] alu_ctrl;
      logic       md;
      logic [2:0] md_op;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // alt is instr[30] for R-type; callers mask it for I-type except SRAI.
   function automatic logic [3:0] alu_decode(input logic [2:0] func3, input logic alt);
      case (func3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational RV32I(+M) main/ALU decoder producing the D-stage control bundle.
// Any unrecognised or disabled encoding collapses to a bubble with illegal set.
module riscv_ctrl_decode
   import riscv_ctrl_pkg::*;
#(
   parameter int EN_M = 1
) (
   input  logic [31:0] instr,
   output ctrl_t       ctrl
);

   logic [6:0] op;
   logic [2:0] func3;
   logic       f7_alt;
   logic       f7_m;
   logic       bad;
   logic       unused_bits;

   assign op          = instr[6:0];
   assign func3       = instr[14:12];
   assign f7_alt      = instr[30];
   assign f7_m        = instr[25];
   assign unused_bits = ^{instr[31], instr[29:26], instr[24:15], instr[11:7]};

   always_comb begin
      ctrl = CTRL_BUBBLE;
      bad  = 1'b0;
      case (op)
         OP_REG: begin
            ctrl.reg_write = 1'b1;
            if (f7_m) begin
               if (EN_M != 0 && !f7_alt) begin
                  ctrl.md    = 1'b1;
                  ctrl.md_op = func3;
               end else begin
                  bad = 1'b1;
               end
            end else begin
               ctrl.alu_ctrl = alu_decode(func3, f7_alt);
            end
         end
         OP_IMM: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.imm_src   = IMM_I;
            ctrl.alu_ctrl  = alu_decode(func3, f7_alt && func3 == 3'b101);
         end
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RESULT_MEM;
            ctrl.imm_src    = IMM_I;
            bad = (func3 == 3'b011) || (func3[2:1] == 2'b11);
         end
         OP_STORE: begin
            ctrl.mem_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.imm_src   = IMM_S;
            bad = func3[2] || (func3[1:0] == 2'b11);
         end
         OP_BRANCH: begin
            ctrl.imm_src  = IMM_B;
            ctrl.alu_ctrl = ALU_SUB;
            case (func3)
               3'b000:  ctrl.branch = BRANCH_BEQ;
               3'b001:  ctrl.branch = BRANCH_BNE;
               3'b100:  ctrl.branch = BRANCH_BLT;
               3'b101:  ctrl.branch = BRANCH_BGE;
               3'b110:  ctrl.branch = BRANCH_BLTU;
               3'b111:  ctrl.branch = BRANCH_BGEU;
               default: bad = 1'b1;
            endcase
         end
         OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = RESULT_PC4;
            ctrl.jump       = JUMP_JAL;
            ctrl.imm_src    = IMM_J;
         end
         OP_JALR: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.result_src = RESULT_PC4;
            ctrl.jump       = JUMP_JALR;
            ctrl.imm_src    = IMM_I;
            bad = (func3 != 3'b000);
         end
         OP_LUI: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.lui       = 1'b1;
            ctrl.imm_src   = IMM_U;
         end
         // AUIPC differs from LUI only in operand A (PC instead of zero).
         OP_AUIPC: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.imm_src   = IMM_U;
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         ctrl         = CTRL_BUBBLE;
         ctrl.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/riscv_id_ex_ctrl_stage.sv
// D->E control register with stall/flush bubble insertion and a multi-cycle
// sequencer that keeps an M-extension op resident in E until its latency expires.
module riscv_id_ex_ctrl_stage
   import riscv_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 4,
   parameter int EN_M       = 1,
   parameter int MUL_LAT    = 2,
   parameter int DIV_LAT    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           instrD,
   input  logic                  stallE,
   input  logic                  flushE,
   output logic                  regWriteE,
   output logic                  memWriteE,
   output logic                  AluSrcE,
   output logic                  luiE,
   output logic [1:0]            resultSrcE,
   output logic [1:0]            JumpE,
   output logic [2:0]            BranchE,
   output logic [2:0]            immSrcE,
   output logic [ALU_CTRL_W-1:0] AluControlE,
   output logic [2:0]            mdOpE,
   output logic                  mdValidE,
   output logic                  illegalE,
   output logic                  mdBusy
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   typedef enum logic {IDLE, BUSY} md_state_t;

   ctrl_t            d_ctrl;
   ctrl_t            e_reg;
   md_state_t        state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] load_lat;

   riscv_ctrl_decode #(.EN_M(EN_M)) u_decode (
      .instr (instrD),
      .ctrl  (d_ctrl)
   );

   // Cycles remaining after the load edge; zero means single-cycle (no BUSY).
   assign load_lat = d_ctrl.md_op[2] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
   assign mdBusy   = (cnt_reg != '0);

   always_ff @(posedge clk) begin
      if (rst || flushE) begin
         e_reg     <= CTRL_BUBBLE;
         cnt_reg   <= '0;
         state_reg <= IDLE;
      end else if (stallE || mdBusy) begin
         if (state_reg == BUSY) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1))
               state_reg <= IDLE;
         end
      end else begin
         e_reg <= d_ctrl;
         if (d_ctrl.md && load_lat != '0) begin
            cnt_reg   <= load_lat;
            state_reg <= BUSY;
         end else begin
            cnt_reg   <= '0;
            state_reg <= IDLE;
         end
      end
   end

   assign regWriteE   = e_reg.reg_write;
   assign memWriteE   = e_reg.mem_write;
   assign AluSrcE     = e_reg.alu_src;
   assign luiE        = e_reg.lui;
   assign resultSrcE  = e_reg.result_src;
   assign JumpE       = e_reg.jump;
   assign BranchE     = e_reg.branch;
   assign immSrcE     = e_reg.imm_src;
   assign AluControlE = ALU_CTRL_W'(e_reg.alu_ctrl);
   assign mdOpE       = e_reg.md_op;
   assign mdValidE    = e_reg.md && (cnt_reg == '0);
   assign illegalE    = e_reg.illegal;

endmodule

// File: tb/tb_riscv_id_ex_ctrl_stage.sv
// Scoreboard bench for the D->E control stage: expectations are queued as each
// instruction is driven and popped when the E outputs are sampled on the falling edge.
module tb_riscv_id_ex_ctrl_stage;

   typedef struct packed {
      logic       regw, memw, alusrc, lui;
      logic [1:0] res, jump;
      logic [2:0] br, imm;
      logic [3:0] alu;
      logic [2:0] mdop;
      logic       mdv, ill, busy;
   } vec_t;

   typedef struct {
      logic [31:0] ins;
      logic        st, fl, rs;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst, stallE, flushE;
   logic [31:0] instrD;

   logic       regWriteE, memWriteE, AluSrcE, luiE, mdValidE, illegalE, mdBusy;
   logic [1:0] resultSrcE, JumpE;
   logic [2:0] BranchE, immSrcE, mdOpE;
   logic [3:0] AluControlE;

   logic       n_regWriteE, n_memWriteE, n_AluSrcE, n_luiE, n_mdValidE, n_illegalE, n_mdBusy;
   logic [1:0] n_resultSrcE, n_JumpE;
   logic [2:0] n_BranchE, n_immSrcE, n_mdOpE;
   logic [3:0] n_AluControlE;

   riscv_id_ex_ctrl_stage dut (
      .clk(clk), .rst(rst), .instrD(instrD), .stallE(stallE), .flushE(flushE),
      .regWriteE(regWriteE), .memWriteE(memWriteE), .AluSrcE(AluSrcE), .luiE(luiE),
      .resultSrcE(resultSrcE), .JumpE(JumpE), .BranchE(BranchE), .immSrcE(immSrcE),
      .AluControlE(AluControlE), .mdOpE(mdOpE), .mdValidE(mdValidE),
      .illegalE(illegalE), .mdBusy(mdBusy)
   );

   riscv_id_ex_ctrl_stage #(.EN_M(0)) dut_nom (
      .clk(clk), .rst(rst), .instrD(instrD), .stallE(stallE), .flushE(flushE),
      .regWriteE(n_regWriteE), .memWriteE(n_memWriteE), .AluSrcE(n_AluSrcE), .luiE(n_luiE),
      .resultSrcE(n_resultSrcE), .JumpE(n_JumpE), .BranchE(n_BranchE), .immSrcE(n_immSrcE),
      .AluControlE(n_AluControlE), .mdOpE(n_mdOpE), .mdValidE(n_mdValidE),
      .illegalE(n_illegalE), .mdBusy(n_mdBusy)
   );

   always #5 clk = ~clk;

   vec_t  q[$];
   vec_t  qn[$];
   stim_t sq[$];
   int    vectors = 0;
   int    miscompares = 0;

   vec_t BUB, ILL, ADD_E, SUB_E, LW_E, ADDI_E, SRAI_E, SW_E, JALR_E, LUI_E;
   vec_t DIVB, DIVV, MULB, MULV;

   localparam logic [31:0] I_ADD  = 32'h003100B3;
   localparam logic [31:0] I_SUB  = 32'h403100B3;
   localparam logic [31:0] I_LW   = 32'h0000A083;
   localparam logic [31:0] I_ADDI = 32'hC0000093;
   localparam logic [31:0] I_SRAI = 32'h4030D093;
   localparam logic [31:0] I_SW   = 32'h0020A223;
   localparam logic [31:0] I_JALR = 32'h000100E7;
   localparam logic [31:0] I_LUI  = 32'h123450B7;
   localparam logic [31:0] I_DIV  = 32'h023140B3;
   localparam logic [31:0] I_MUL  = 32'h023100B3;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   function automatic vec_t mk(input logic regw, memw, alusrc, lui,
                               input logic [1:0] res, jump, input logic [2:0] br, imm,
                               input logic [3:0] alu, input logic [2:0] mdop,
                               input logic mdv, ill, busy);
      vec_t v;
      v.regw = regw; v.memw = memw; v.alusrc = alusrc; v.lui = lui;
      v.res = res; v.jump = jump; v.br = br; v.imm = imm; v.alu = alu;
      v.mdop = mdop; v.mdv = mdv; v.ill = ill; v.busy = busy;
      return v;
   endfunction

   // mdOpE is only meaningful while an M op is busy or completing.
   function automatic vec_t obs();
      return mk(regWriteE, memWriteE, AluSrcE, luiE, resultSrcE, JumpE, BranchE, immSrcE,
                AluControlE, (mdValidE | mdBusy) ? mdOpE : 3'd0, mdValidE, illegalE, mdBusy);
   endfunction

   function automatic vec_t obs_n();
      return mk(n_regWriteE, n_memWriteE, n_AluSrcE, n_luiE, n_resultSrcE, n_JumpE, n_BranchE,
                n_immSrcE, n_AluControlE, (n_mdValidE | n_mdBusy) ? n_mdOpE : 3'd0,
                n_mdValidE, n_illegalE, n_mdBusy);
   endfunction

   task automatic step(input logic [31:0] ins, input logic st, fl, rs, input vec_t e);
      stim_t s;
      s.ins = ins; s.st = st; s.fl = fl; s.rs = rs;
      sq.push_back(s);
      q.push_back(e);
   endtask

   task automatic apply(input stim_t s);
      rst = s.rs; stallE = s.st; flushE = s.fl; instrD = s.ins;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      stim_t s; vec_t got, want; int n = 0;
      step(I_ADD, 1'b0, 1'b0, 1'b1, BUB);
      step(I_DIV, 1'b0, 1'b0, 1'b1, BUB);
      while (sq.size() > 0) begin
         s = sq.pop_front(); apply(s);
         got = obs(); want = q.pop_front(); vectors++;
         $display("reset[%0d] instr=%h got=%h", n, s.ins, got);
         if (got !== want) begin
            miscompares++;
            $display("FAIL reset[%0d] instr=%h: got %h expected %h", n, s.ins, got, want);
         end
         n++;
      end
   endtask

   task automatic test_decode();
      stim_t s; vec_t got, want; int n = 0;
      step(I_ADD,  1'b0, 1'b0, 1'b0, ADD_E);
      step(I_SUB,  1'b0, 1'b0, 1'b0, SUB_E);
      step(I_LW,   1'b0, 1'b0, 1'b0, LW_E);
      step(I_ADDI, 1'b0, 1'b0, 1'b0, ADDI_E);
      step(I_SRAI, 1'b0, 1'b0, 1'b0, SRAI_E);
      step(I_SW,   1'b0, 1'b0, 1'b0, SW_E);
      step(I_JALR, 1'b0, 1'b0, 1'b0, JALR_E);
      step(I_LUI,  1'b0, 1'b0, 1'b0, LUI_E);
      while (sq.size() > 0) begin
         s = sq.pop_front(); apply(s);
         got = obs(); want = q.pop_front(); vectors++;
         $display("decode[%0d] instr=%h got=%h", n, s.ins, got);
         if (got !== want) begin
            miscompares++;
            $display("FAIL decode[%0d] instr=%h: got %h expected %h", n, s.ins, got, want);
         end
         n++;
      end
   endtask

   task automatic test_stall_flush();
      stim_t s; vec_t got, want; int n = 0;
      step(I_ADD, 1'b0, 1'b0, 1'b0, ADD_E);
      step(I_SUB, 1'b1, 1'b0, 1'b0, ADD_E);
      step(I_SUB, 1'b0, 1'b0, 1'b0, SUB_E);
      step(I_LW,  1'b1, 1'b1, 1'b0, BUB);
      step(I_LW,  1'b0, 1'b0, 1'b0, LW_E);
      while (sq.size() > 0) begin
         s = sq.pop_front(); apply(s);
         got = obs(); want = q.pop_front(); vectors++;
         $display("stall_flush[%0d] instr=%h st=%b fl=%b got=%h", n, s.ins, s.st, s.fl, got);
         if (got !== want) begin
            miscompares++;
            $display("FAIL stall_flush[%0d] instr=%h: got %h expected %h", n, s.ins, got, want);
         end
         n++;
      end
   endtask

   task automatic test_div();
      stim_t s; vec_t got, want; int n = 0;
      step(I_DIV, 1'b0, 1'b0, 1'b0, DIVB);
      for (int i = 0; i < 6; i++) step(I_SUB, 1'b0, 1'b0, 1'b0, DIVB);
      step(I_SUB, 1'b0, 1'b0, 1'b0, DIVV);
      step(I_SUB, 1'b0, 1'b0, 1'b0, SUB_E);
      while (sq.size() > 0) begin
         s = sq.pop_front(); apply(s);
         got = obs(); want = q.pop_front(); vectors++;
         $display("div[%0d] instr=%h got=%h", n, s.ins, got);
         if (got !== want) begin
            miscompares++;
            $display("FAIL div[%0d] instr=%h: got %h expected %h", n, s.ins, got, want);
         end
         n++;
      end
   endtask

   task automatic test_div_flush();
      stim_t s; vec_t got, want; int n = 0;
      step(I_DIV, 1'b0, 1'b0, 1'b0, DIVB);
      step(I_SUB, 1'b0, 1'b0, 1'b0, DIVB);
      step(I_SUB, 1'b0, 1'b0, 1'b0, DIVB);
      step(I_SUB, 1'b0, 1'b1, 1'b0, BUB);
      step(I_ADD, 1'b0, 1'b0, 1'b0, ADD_E);
      step(I_ADD, 1'b0, 1'b0, 1'b0, ADD_E);
      while (sq.size() > 0) begin
         s = sq.pop_front(); apply(s);
         got = obs(); want = q.pop_front(); vectors++;
         $display("div_flush[%0d] instr=%h fl=%b got=%h", n, s.ins, s.fl, got);
         if (got !== want) begin
            miscompares++;
            $display("FAIL div_flush[%0d] instr=%h: got %h expected %h", n, s.ins, got, want);
         end
         n++;
      end
   endtask

   task automatic test_div_stall();
      stim_t s; vec_t got, want; int n = 0;
      step(I_DIV, 1'b0, 1'b0, 1'b0, DIVB);
      for (int i = 0; i < 6; i++) step(I_SUB, 1'b1, 1'b0, 1'b0, DIVB);
      step(I_SUB, 1'b0, 1'b0, 1'b0, DIVV);
      step(I_LW,  1'b0, 1'b0, 1'b0, LW_E);
      while (sq.size() > 0) begin
         s = sq.pop_front(); apply(s);
         got = obs(); want = q.pop_front(); vectors++;
         $display("div_stall[%0d] instr=%h st=%b got=%h", n, s.ins, s.st, got);
         if (got !== want) begin
            miscompares++;
            $display("FAIL div_stall[%0d] instr=%h: got %h expected %h", n, s.ins, got, want);
         end
         n++;
      end
   endtask

   task automatic test_back_to_back();
      stim_t s; vec_t got, want; int n = 0;
      step(I_DIV, 1'b0, 1'b0, 1'b0, DIVB);
      for (int i = 0; i < 6; i++) step(I_ADD, 1'b0, 1'b0, 1'b0, DIVB);
      step(I_ADD, 1'b0, 1'b0, 1'b0, DIVV);
      step(I_MUL, 1'b0, 1'b0, 1'b0, MULB);
      step(I_ADD, 1'b0, 1'b0, 1'b0, MULV);
      step(I_ADD, 1'b0, 1'b0, 1'b0, ADD_E);
      while (sq.size() > 0) begin
         s = sq.pop_front(); apply(s);
         got = obs(); want = q.pop_front(); vectors++;
         $display("back_to_back[%0d] instr=%h got=%h", n, s.ins, got);
         if (got !== want) begin
            miscompares++;
            $display("FAIL back_to_back[%0d] instr=%h: got %h expected %h", n, s.ins, got, want);
         end
         n++;
      end
   endtask

   task automatic test_reset_busy();
      stim_t s; vec_t got, want; int n = 0;
      step(I_DIV, 1'b0, 1'b0, 1'b0, DIVB);
      step(I_ADD, 1'b0, 1'b0, 1'b0, DIVB);
      step(I_ADD, 1'b0, 1'b0, 1'b1, BUB);
      step(I_ADD, 1'b0, 1'b0, 1'b0, ADD_E);
      while (sq.size() > 0) begin
         s = sq.pop_front(); apply(s);
         got = obs(); want = q.pop_front(); vectors++;
         $display("reset_busy[%0d] instr=%h rs=%b got=%h", n, s.ins, s.rs, got);
         if (got !== want) begin
            miscompares++;
            $display("FAIL reset_busy[%0d] instr=%h: got %h expected %h", n, s.ins, got, want);
         end
         n++;
      end
   endtask

   task automatic test_illegal();
      stim_t s; vec_t got, want, got_n, want_n; int n = 0;
      step(I_BAD, 1'b0, 1'b0, 1'b0, ILL);  qn.push_back(ILL);
      step(I_MUL, 1'b0, 1'b0, 1'b0, MULB); qn.push_back(ILL);
      step(I_ADD, 1'b0, 1'b0, 1'b0, MULV); qn.push_back(ADD_E);
      step(I_ADD, 1'b0, 1'b0, 1'b0, ADD_E); qn.push_back(ADD_E);
      while (sq.size() > 0) begin
         s = sq.pop_front(); apply(s);
         got = obs(); want = q.pop_front(); vectors++;
         got_n = obs_n(); want_n = qn.pop_front(); vectors++;
         $display("illegal[%0d] instr=%h got=%h got_no_m=%h", n, s.ins, got, got_n);
         if (got !== want) begin
            miscompares++;
            $display("FAIL illegal[%0d] instr=%h: got %h expected %h", n, s.ins, got, want);
         end
         if (got_n !== want_n) begin
            miscompares++;
            $display("FAIL illegal_no_m[%0d] instr=%h: got %h expected %h", n, s.ins, got_n, want_n);
         end
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      BUB    = mk(0,0,0,0, 2'd0,2'd0, 3'd0,3'd0, 4'd0, 3'd0, 0,0,0);
      ILL    = mk(0,0,0,0, 2'd0,2'd0, 3'd0,3'd0, 4'd0, 3'd0, 0,1,0);
      ADD_E  = mk(1,0,0,0, 2'd0,2'd0, 3'd0,3'd0, 4'd0, 3'd0, 0,0,0);
      SUB_E  = mk(1,0,0,0, 2'd0,2'd0, 3'd0,3'd0, 4'd1, 3'd0, 0,0,0);
      LW_E   = mk(1,0,1,0, 2'd1,2'd0, 3'd0,3'd0, 4'd0, 3'd0, 0,0,0);
      ADDI_E = mk(1,0,1,0, 2'd0,2'd0, 3'd0,3'd0, 4'd0, 3'd0, 0,0,0);
      SRAI_E = mk(1,0,1,0, 2'd0,2'd0, 3'd0,3'd0, 4'd8, 3'd0, 0,0,0);
      SW_E   = mk(0,1,1,0, 2'd0,2'd0, 3'd0,3'd1, 4'd0, 3'd0, 0,0,0);
      JALR_E = mk(1,0,1,0, 2'd2,2'd2, 3'd0,3'd0, 4'd0, 3'd0, 0,0,0);
      LUI_E  = mk(1,0,1,1, 2'd0,2'd0, 3'd0,3'd3, 4'd0, 3'd0, 0,0,0);
      DIVB   = mk(1,0,0,0, 2'd0,2'd0, 3'd0,3'd0, 4'd0, 3'd4, 0,0,1);
      DIVV   = mk(1,0,0,0, 2'd0,2'd0, 3'd0,3'd0, 4'd0, 3'd4, 1,0,0);
      MULB   = mk(1,0,0,0, 2'd0,2'd0, 3'd0,3'd0, 4'd0, 3'd0, 0,0,1);
      MULV   = mk(1,0,0,0, 2'd0,2'd0, 3'd0,3'd0, 4'd0, 3'd0, 1,0,0);

      rst = 1'b1; stallE = 1'b0; flushE = 1'b0; instrD = '0;
      @(negedge clk);

      test_reset();
      test_decode();
      test_stall_flush();
      test_div();
      test_div_flush();
      test_div_stall();
      test_back_to_back();
      test_reset_busy();
      test_illegal();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
